// File: rtl/prog_pkg.sv
// Shared program-loader definitions: frame state encoding, sync marker and
// program memory address width. The processor core imports these as well.
package prog_pkg;

    localparam int         ADDR_W       = 6;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM
    } prog_state_t;

endpackage

// File: rtl/prog_csum.sv
// Modulo-256 frame checksum accumulator. The good flag looks ahead by adding
// the byte currently offered, so it is valid on the CSUM acceptance cycle.
module prog_csum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] data,
    output logic       good
);

    logic [7:0] sum;
    logic [7:0] total;

    assign total = sum + data;
    assign good  = (total == 8'h00);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sum <= 8'h00;
        end else if (add) begin
            sum <= total;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: hunts for a sync byte, writes the framed payload into
// program memory and releases the processor only after a good checksum.
//
// state  | meaning
// HUNT   | discard bytes until SYNC_BYTE; processor may be running
// ADDR   | next byte is the start address (low 6 bits)
// LEN    | next byte is the payload length; zero aborts the frame
// DATA   | payload bytes, each written one cycle after acceptance
// CSUM   | final byte closes the frame; total must be 8'h00
module prog_loader
    import prog_pkg::*;
#(
    parameter int         MEM_DEPTH = 64,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT,
    parameter int         TIMEOUT   = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              mem_stall,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              err
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    prog_state_t       state;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              accept;
    logic              idle_hit;
    logic              csum_clear;
    logic              csum_add;
    logic              csum_good;

    assign in_ready   = !mem_stall && !rst;
    assign accept     = in_valid && in_ready;
    assign idle_hit   = (idle_cnt == IDLE_W'(TIMEOUT - 1));
    assign csum_clear = accept && (state == S_HUNT) && (in_data == SYNC_BYTE);
    assign csum_add   = accept && (state == S_ADDR || state == S_LEN || state == S_DATA);

    prog_csum u_csum (
        .clk   (clk),
        .rst   (rst),
        .clear (csum_clear),
        .add   (csum_add),
        .data  (in_data),
        .good  (csum_good)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_HUNT;
            ptr       <= '0;
            cnt       <= 8'h00;
            idle_cnt  <= '0;
            cpu_run   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;

            // A stalled memory port still counts as idle time mid-frame.
            if (state == S_HUNT || accept) begin
                idle_cnt <= '0;
            end else if (idle_hit) begin
                idle_cnt <= '0;
                err      <= 1'b1;
                state    <= S_HUNT;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (accept) begin
                case (state)
                    S_HUNT: begin
                        if (in_data == SYNC_BYTE) begin
                            state   <= S_ADDR;
                            cpu_run <= 1'b0;
                        end
                    end
                    S_ADDR: begin
                        ptr   <= in_data[ADDR_W-1:0];
                        state <= S_LEN;
                    end
                    S_LEN: begin
                        cnt <= in_data;
                        if (in_data == 8'h00) begin
                            err   <= 1'b1;
                            state <= S_HUNT;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= ptr;
                        mem_wdata <= in_data;
                        ptr       <= (ptr == ADDR_W'(MEM_DEPTH - 1)) ? '0 : ptr + 1'b1;
                        cnt       <= cnt - 1'b1;
                        if (cnt == 8'h01) begin
                            state <= S_CSUM;
                        end
                    end
                    S_CSUM: begin
                        if (csum_good) begin
                            done    <= 1'b1;
                            cpu_run <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= S_HUNT;
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good/bad frames, address wrap, zero length,
// mid-frame timeout and reset during a stalled frame.
`define CHK(tag, obs, exp) begin \
    n_tests++; \
    assert ((obs) === (exp)) else begin \
        n_fail++; \
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
    end \
end

module tb_prog_loader;
    import prog_pkg::*;

    localparam int TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       mem_stall;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_run;
    logic       done;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt;
    int done_cnt;
    int we_cnt;
    int first_err;

    prog_loader #(.MEM_DEPTH(64), .SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_stall (mem_stall),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_run   (cpu_run),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        mem_stall = 1'b0;
        idle(2);
        `CHK("rst_in_ready", in_ready, 1'b0)
        `CHK("rst_cpu_run", cpu_run, 1'b0)
        `CHK("rst_mem_we", mem_we, 1'b0)
        `CHK("rst_done_err", {done, err}, 2'b00)
        rst = 1'b0;
        #1;
        `CHK("in_ready_idle", in_ready, 1'b1)
        idle(1);

        // Good frame: A5 00 02 20 00 DE
        send(8'hA5);
        `CHK("a_cpu_run_low", cpu_run, 1'b0)
        send(8'h00);
        send(8'h02);
        `CHK("a_no_we_hdr", mem_we, 1'b0)
        send(8'h20);
        `CHK("a_wr0", {mem_we, mem_addr, mem_wdata}, {1'b1, 6'd0, 8'h20})
        send(8'h00);
        `CHK("a_wr1", {mem_we, mem_addr, mem_wdata}, {1'b1, 6'd1, 8'h00})
        send(8'hDE);
        `CHK("a_done_err", {done, err}, 2'b10)
        `CHK("a_cpu_run", cpu_run, 1'b1)
        `CHK("a_we_off", mem_we, 1'b0)
        idle(1);
        `CHK("a_done_pulse", done, 1'b0)

        // Same frame with bad checksum DF
        send(8'hA5);
        `CHK("b_cpu_run_drop", cpu_run, 1'b0)
        send(8'h00);
        send(8'h02);
        send(8'h20);
        `CHK("b_wr0", {mem_we, mem_addr, mem_wdata}, {1'b1, 6'd0, 8'h20})
        send(8'h00);
        `CHK("b_wr1", {mem_we, mem_addr, mem_wdata}, {1'b1, 6'd1, 8'h00})
        send(8'hDF);
        `CHK("b_done_err", {done, err}, 2'b01)
        `CHK("b_cpu_run", cpu_run, 1'b0)
        idle(1);

        // Wrap 63 -> 0; 3F+02+11+22 = 74, so closing byte 8C totals 00
        send(8'hA5);
        send(8'h3F);
        send(8'h02);
        send(8'h11);
        `CHK("c_wr63", {mem_we, mem_addr, mem_wdata}, {1'b1, 6'd63, 8'h11})
        send(8'h22);
        `CHK("c_wr0", {mem_we, mem_addr, mem_wdata}, {1'b1, 6'd0, 8'h22})
        send(8'h8C);
        `CHK("c_done_err", {done, err}, 2'b10)
        `CHK("c_cpu_run", cpu_run, 1'b1)
        idle(1);

        // Noise then zero length: 00 FF A5 05 00
        send(8'h00);
        send(8'hFF);
        `CHK("d_noise_run", cpu_run, 1'b1)
        send(8'hA5);
        send(8'h05);
        send(8'h00);
        `CHK("d_len0_err", {done, err, mem_we}, 3'b010)
        `CHK("d_hunt", dut.state, S_HUNT)
        idle(1);

        // Timeout after one data byte
        send(8'hA5);
        send(8'h00);
        send(8'h04);
        send(8'h01);
        `CHK("e_wr0", {mem_we, mem_addr, mem_wdata}, {1'b1, 6'd0, 8'h01})
        err_cnt   = 0;
        done_cnt  = 0;
        first_err = 0;
        for (int i = 1; i <= TIMEOUT + 5; i++) begin
            @(posedge clk);
            #1;
            if (err) begin
                err_cnt++;
                if (first_err == 0) first_err = i;
            end
            if (done) done_cnt++;
        end
        `CHK("e_err_count", err_cnt, 1)
        `CHK("e_err_edge", first_err, TIMEOUT)
        `CHK("e_no_done", done_cnt, 0)
        `CHK("e_cpu_run", cpu_run, 1'b0)
        send(8'hA5);
        send(8'h10);
        send(8'h01);
        send(8'h55);
        `CHK("e_next_wr", {mem_we, mem_addr, mem_wdata}, {1'b1, 6'd16, 8'h55})
        send(8'h9A);
        `CHK("e_next_done", {done, err, cpu_run}, 3'b101)
        idle(1);

        // Reset during DATA while the memory port stalls
        send(8'hA5);
        send(8'h08);
        send(8'h03);
        send(8'hAA);
        `CHK("f_wr8", {mem_we, mem_addr, mem_wdata}, {1'b1, 6'd8, 8'hAA})
        mem_stall = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hBB;
        #1;
        `CHK("f_stall_ready", in_ready, 1'b0)
        idle(2);
        `CHK("f_stall_no_we", mem_we, 1'b0)
        mem_stall = 1'b0;
        rst       = 1'b1;
        #1;
        `CHK("f_rst_ready", in_ready, 1'b0)
        idle(1);
        mem_stall = 1'b1;
        idle(1);
        `CHK("f_rst_outs", {mem_we, mem_addr, mem_wdata, cpu_run, done, err}, 18'h0)
        `CHK("f_rst_state", dut.state, S_HUNT)
        rst       = 1'b0;
        mem_stall = 1'b0;
        in_valid  = 1'b0;
        we_cnt    = 0;
        send(8'h05);
        if (mem_we) we_cnt++;
        send(8'h06);
        if (mem_we) we_cnt++;
        send(8'hCC);
        if (mem_we) we_cnt++;
        idle(2);
        if (mem_we) we_cnt++;
        `CHK("f_no_we_after_rst", we_cnt, 0)
        `CHK("f_flags_after_rst", {done, err, cpu_run}, 3'b000)

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
